// File: rtl/chan_readout_seq.sv
`default_nettype none
// ============================================================================
//  Module      : chan_readout_seq
//  Description : Readout sequencer behind the two-channel ADC switch. Issues
//                buffer read strobes line by line, captures the returned
//                samples into a 2-entry output FIFO and streams pixels with
//                line/frame markers under ready/valid backpressure. In
//                two-channel mode even lines come from CAN1 and odd lines
//                from CAN2.
//  Revision    : 1.0 - initial release
// ============================================================================
module chan_readout_seq #(
  parameter int DATA_W   = 14,
  parameter int LINE_LEN = 384,
  parameter int LINES    = 288
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              numb_chan,
  input  logic              buf_rdy_can1,
  input  logic              buf_rdy_can2,
  input  logic [DATA_W-1:0] data_in,
  output logic              in_buf_en,
  output logic              number_chan,
  output logic              numb_chan_out,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              line_end,
  output logic              frame_end,
  output logic              busy
);

  localparam int PIX_W  = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int LINE_W = (LINES > 1) ? $clog2(LINES) : 1;

  localparam logic [PIX_W-1:0]  C_LAST_PIX  = PIX_W'(LINE_LEN - 1);
  localparam logic [LINE_W-1:0] C_LAST_LINE = LINE_W'(LINES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_BUF = 2'd1,
    S_READ     = 2'd2,
    S_DRAIN    = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Frame configuration and position
  logic              r_mode;
  logic [PIX_W-1:0]  r_pix_cnt;
  logic [LINE_W-1:0] r_line_cnt;

  // Read issued last cycle: its sample is on data_in this cycle
  logic              r_inflight;
  logic              r_inflight_le;
  logic              r_inflight_fe;

  // 2-entry output FIFO, markers travel with each sample
  logic [DATA_W-1:0] r_fifo_data [2];
  logic [1:0]        r_fifo_le;
  logic [1:0]        r_fifo_fe;
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_fifo_cnt;

  logic w_sel;
  logic w_sel_rdy;
  logic w_room;
  logic w_issue;
  logic w_last_pix;
  logic w_last_line;
  logic w_line_done;
  logic w_drained;
  logic w_start_acc;
  logic w_push;
  logic w_pop;

  assign w_start_acc = start && (r_state == S_IDLE);
  assign w_sel       = r_line_cnt[0] & r_mode;
  assign w_sel_rdy   = w_sel ? buf_rdy_can2 : buf_rdy_can1;
  assign w_last_pix  = (r_pix_cnt == C_LAST_PIX);
  assign w_last_line = (r_line_cnt == C_LAST_LINE);

  // A new read is allowed only when the FIFO can absorb it together with
  // any sample still in flight, so the FIFO can never overflow.
  assign w_room    = (r_fifo_cnt == 2'd0) || ((r_fifo_cnt == 2'd1) && !r_inflight);
  assign w_drained = (r_fifo_cnt == 2'd0) && !r_inflight;

  assign w_push = r_inflight;
  assign w_pop  = pix_valid && pix_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and read issue
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_line_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_WAIT_BUF;
        end
      end
      S_WAIT_BUF: begin
        if (w_sel_rdy) begin
          w_state_nxt = S_READ;
        end
      end
      S_READ: begin
        w_issue = w_room;
        if (w_room && w_last_pix) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_drained) begin
          w_line_done = 1'b1;
          w_state_nxt = w_last_line ? S_IDLE : S_WAIT_BUF;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Mode is captured only on an accepted start and held for the frame
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode <= 1'b0;
    end else if (w_start_acc) begin
      r_mode <= numb_chan;
    end
  end

  // Pixel counter tracks issued reads within the current line
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pix_cnt <= '0;
    end else if (w_issue) begin
      r_pix_cnt <= w_last_pix ? '0 : r_pix_cnt + 1'b1;
    end
  end

  // Line counter advances once a line has fully drained downstream
  always_ff @(posedge clk) begin
    if (rst) begin
      r_line_cnt <= '0;
    end else if (w_line_done) begin
      r_line_cnt <= w_last_line ? '0 : r_line_cnt + 1'b1;
    end
  end

  // In-flight tracker: markers are decided at issue time and follow the sample
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight    <= 1'b0;
      r_inflight_le <= 1'b0;
      r_inflight_fe <= 1'b0;
    end else begin
      r_inflight    <= w_issue;
      r_inflight_le <= w_issue && w_last_pix;
      r_inflight_fe <= w_issue && w_last_pix && w_last_line;
    end
  end

  // Output FIFO storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_fifo_data[i] <= '0;
      end
      r_fifo_le  <= 2'b00;
      r_fifo_fe  <= 2'b00;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_fifo_cnt <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= data_in;
        r_fifo_le[r_wr_ptr]   <= r_inflight_le;
        r_fifo_fe[r_wr_ptr]   <= r_inflight_fe;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  // Outputs are gated by valid so nothing stale shows on an empty FIFO
  assign pix_valid     = (r_fifo_cnt != 2'd0);
  assign pix_data      = pix_valid ? r_fifo_data[r_rd_ptr] : '0;
  assign line_end      = pix_valid && r_fifo_le[r_rd_ptr];
  assign frame_end     = pix_valid && r_fifo_fe[r_rd_ptr];
  assign in_buf_en     = w_issue;
  assign number_chan   = w_sel;
  assign numb_chan_out = r_mode;
  assign busy          = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_chan_readout_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_chan_readout_seq
//  Description : Self-checking bench for chan_readout_seq. Per-channel sample
//                sources answer read strobes; the expected pixel stream is
//                derived from the line/channel interleave rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_chan_readout_seq;

  localparam int DATA_W   = 14;
  localparam int LINE_LEN = 4;
  localparam int LINES    = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              numb_chan = 1'b0;
  logic              buf_rdy_can1 = 1'b1;
  logic              buf_rdy_can2 = 1'b1;
  logic [DATA_W-1:0] data_in = '0;
  logic              pix_ready = 1'b1;
  logic              in_buf_en;
  logic              number_chan;
  logic              numb_chan_out;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              line_end;
  logic              frame_end;
  logic              busy;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic              le;
    logic              fe;
  } pix_t;

  int                tests = 0;
  int                fails = 0;
  pix_t              exp_q[$];
  logic [DATA_W-1:0] ch_q0[$];
  logic [DATA_W-1:0] ch_q1[$];
  int                acc_cnt = 0;
  int                ready_mode = 0;
  logic              strobe_seen = 1'b0;
  logic              chan_seen = 1'b0;
  int                occ_cnt = 0;
  logic              occ_inf = 1'b0;
  pix_t              mon_e;

  chan_readout_seq #(
    .DATA_W   (DATA_W),
    .LINE_LEN (LINE_LEN),
    .LINES    (LINES)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .numb_chan     (numb_chan),
    .buf_rdy_can1  (buf_rdy_can1),
    .buf_rdy_can2  (buf_rdy_can2),
    .data_in       (data_in),
    .in_buf_en     (in_buf_en),
    .number_chan   (number_chan),
    .numb_chan_out (numb_chan_out),
    .pix_data      (pix_data),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready),
    .line_end      (line_end),
    .frame_end     (frame_end),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Stream monitor and FIFO occupancy model, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      occ_cnt = 0;
      occ_inf = 1'b0;
    end else begin
      if (in_buf_en) chk("issue_room", 32'(occ_cnt + int'(occ_inf) < 2), 1);
      chk("valid_vs_occ", pix_valid, occ_cnt != 0);
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_pixel", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("pix_data", pix_data, mon_e.d);
          chk("line_end", line_end, mon_e.le);
          chk("frame_end", frame_end, mon_e.fe);
        end
        acc_cnt++;
      end
      occ_cnt = occ_cnt + int'(occ_inf) - ((pix_valid && pix_ready) ? 1 : 0);
      occ_inf = in_buf_en;
    end
    strobe_seen = in_buf_en && !rst;
    chan_seen   = number_chan;
  end

  // Switch model answers each strobe one cycle later; consumer readiness pattern
  always @(posedge clk) begin
    #1;
    if (strobe_seen) begin
      if (!chan_seen && ch_q0.size() > 0) data_in = ch_q0.pop_front();
      else if (chan_seen && ch_q1.size() > 0) data_in = ch_q1.pop_front();
      else data_in = '1;
    end else begin
      data_in = DATA_W'($urandom);
    end
    case (ready_mode)
      0:       pix_ready = 1'b1;
      1:       pix_ready = ~pix_ready;
      default: pix_ready = ($urandom_range(0, 2) != 0);
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected frame: line l comes from channel (mode && l odd), in order
  task automatic build_frame(input logic mode);
    logic [DATA_W-1:0] v;
    pix_t e;
    for (int l = 0; l < LINES; l++) begin
      for (int p = 0; p < LINE_LEN; p++) begin
        v = DATA_W'($urandom);
        if (mode && (l % 2 == 1)) ch_q1.push_back(v);
        else ch_q0.push_back(v);
        e.d  = v;
        e.le = (p == LINE_LEN - 1);
        e.fe = (p == LINE_LEN - 1) && (l == LINES - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic pulse_start(input logic mode);
    numb_chan = mode;
    start     = 1'b1;
    step();
    start     = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("mode_latched", numb_chan_out, mode);
  endtask

  task automatic wait_frame(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 400) begin
      step();
      n++;
    end
    chk({tag, "_timeout"}, 32'(n < 400), 1);
    chk({tag, "_all_out"}, exp_q.size(), 0);
    chk({tag, "_busy_low"}, busy, 0);
  endtask

  task automatic wait_acc(input int target, input string tag);
    int n = 0;
    while (acc_cnt < target && n < 200) begin
      step();
      n++;
    end
    chk({tag, "_timeout"}, 32'(n < 200), 1);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_in_buf_en"}, in_buf_en, 0);
    chk({tag, "_number_chan"}, number_chan, 0);
    chk({tag, "_numb_chan_out"}, numb_chan_out, 0);
    chk({tag, "_pix_data"}, pix_data, 0);
    chk({tag, "_pix_valid"}, pix_valid, 0);
    chk({tag, "_line_end"}, line_end, 0);
    chk({tag, "_frame_end"}, frame_end, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int base;
    logic m;
    // Reset state
    repeat (3) step();
    chk_outputs_zero("reset");
    rst = 1'b0;
    step();
    chk_outputs_zero("post_reset");

    // One-channel frame, ready held high
    build_frame(1'b0);
    pulse_start(1'b0);
    wait_frame("t1");

    // Two-channel interleave
    build_frame(1'b1);
    pulse_start(1'b1);
    wait_frame("t2");

    // Backpressure: toggling then random ready
    ready_mode = 1;
    build_frame(1'b1);
    pulse_start(1'b1);
    wait_frame("t3_toggle");
    ready_mode = 2;
    for (int k = 0; k < 4; k++) begin
      m = 1'($urandom_range(0, 1));
      build_frame(m);
      pulse_start(m);
      wait_frame("t3_random");
    end
    ready_mode = 0;

    // CAN2 not ready on line 1: sequencer must wait
    buf_rdy_can2 = 1'b0;
    base = acc_cnt;
    build_frame(1'b1);
    pulse_start(1'b1);
    wait_acc(base + LINE_LEN, "t4_line0");
    step();
    step();
    chk("t4_number_chan", number_chan, 1);
    for (int k = 0; k < 20; k++) begin
      chk("t4_no_read", in_buf_en, 0);
      step();
    end
    chk("t4_still_busy", busy, 1);
    buf_rdy_can2 = 1'b1;
    wait_frame("t4");

    // START and NUMB_CHAN changes while busy are ignored
    build_frame(1'b0);
    pulse_start(1'b0);
    step();
    numb_chan = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t5_mode_held", numb_chan_out, 0);
    chk("t5_chan_sel", number_chan, 0);
    step();
    numb_chan = 1'b0;
    step();
    numb_chan = 1'b1;
    wait_frame("t5");
    chk("t5_mode_after", numb_chan_out, 0);

    // Reset mid-frame at pixel 2 of line 1, then a clean restart
    base = acc_cnt;
    build_frame(1'b1);
    pulse_start(1'b1);
    wait_acc(base + LINE_LEN + 3, "t6_reach");
    rst = 1'b1;
    step();
    chk_outputs_zero("t6_abort");
    rst = 1'b0;
    exp_q.delete();
    ch_q0.delete();
    ch_q1.delete();
    step();
    build_frame(1'b1);
    pulse_start(1'b1);
    wait_frame("t6_restart");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
